rf_multi: RTL

Parametrised successor of the 4x16 register file. Provides:
- configurable word width and register count
- two combinational read ports and one synchronous write port
- a per-register pending (scoreboard) bit for the pipelined datapath
- a sequential one-register-per-cycle clear engine

Sits in the CPU datapath between decode (read/reserve) and writeback (write).

---
 rtl/rf_multi.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rf_multi.sv
// rf_multi: parametrised multi-port register file with per-register pending
// (scoreboard) bits and a sequential one-register-per-cycle clear engine.
//   - two combinational read ports (data/pending), one synchronous write port
//   - reserve port that marks a register pending until its producer writes it
//   - IDLE/CLEAR engine that zeroes one register and pending bit per cycle
// Optional feature, enabled by defining macro RF_BYPASS_EN:
//   write-through forwarding of data3 (and pending state) to both read ports.
module rf_multi #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_REG   = 4,
    parameter int ADDR_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [ADDR_W-1:0]    addr3,
    input  logic [WORD_SIZE-1:0] data3,
    input  logic [ADDR_W-1:0]    addr1,
    input  logic [ADDR_W-1:0]    addr2,
    output logic [WORD_SIZE-1:0] data1,
    output logic [WORD_SIZE-1:0] data2,
    input  logic                 rsv,
    input  logic [ADDR_W-1:0]    rsv_addr,
    output logic                 pend1,
    output logic                 pend2,
    input  logic                 clr_start,
    output logic                 clr_busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Last register index visited by the clear engine.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REG - 1);

    state_t                 r_state;
    logic [ADDR_W-1:0]      r_idx;
    logic [WORD_SIZE-1:0]   r_regs [NUM_REG];
    logic [NUM_REG-1:0]     r_pend;
    logic                   r_clr_busy;

    logic [WORD_SIZE-1:0]   w_data1;
    logic [WORD_SIZE-1:0]   w_data2;
    logic                   w_pend1;
    logic                   w_pend2;

    // Register array, pending bits and clear-engine FSM; reset has top priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_REG; k++) begin
                r_regs[k] <= {WORD_SIZE{1'b0}};
            end
            r_pend     <= {NUM_REG{1'b0}};
            r_state    <= ST_IDLE;
            r_idx      <= {ADDR_W{1'b0}};
            r_clr_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A retiring write clears pending; a same-edge reserve is
                    // applied afterwards so that the set wins on collision.
                    if (write) begin
                        r_regs[addr3] <= data3;
                        r_pend[addr3] <= 1'b0;
                    end else begin
                        r_pend <= r_pend;
                    end
                    if (rsv) begin
                        r_pend[rsv_addr] <= 1'b1;
                    end else begin
                        r_idx <= r_idx;
                    end
                    // Start clearing; anything written at this edge is wiped later.
                    if (clr_start) begin
                        r_state    <= ST_CLEAR;
                        r_idx      <= {ADDR_W{1'b0}};
                        r_clr_busy <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_clr_busy <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    // write, rsv and clr_start are all ignored while clearing.
                    r_regs[r_idx] <= {WORD_SIZE{1'b0}};
                    r_pend[r_idx] <= 1'b0;
                    r_idx         <= r_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (r_idx == LAST_IDX) begin
                        r_state    <= ST_IDLE;
                        r_clr_busy <= 1'b0;
                    end else begin
                        r_state    <= ST_CLEAR;
                        r_clr_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_idx      <= {ADDR_W{1'b0}};
                    r_clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // Combinational read ports, optionally forwarding the in-flight write.
    always_comb begin
        w_data1 = r_regs[addr1];
        w_pend1 = r_pend[addr1];
        w_data2 = r_regs[addr2];
        w_pend2 = r_pend[addr2];
`ifdef RF_BYPASS_EN
        // Forwarding only exists in IDLE, where the write would actually land.
        if (write && (r_state == ST_IDLE) && (addr3 == addr1)) begin
            w_data1 = data3;
            w_pend1 = rsv && (rsv_addr == addr1);
        end else begin
            w_data1 = r_regs[addr1];
            w_pend1 = r_pend[addr1];
        end
        if (write && (r_state == ST_IDLE) && (addr3 == addr2)) begin
            w_data2 = data3;
            w_pend2 = rsv && (rsv_addr == addr2);
        end else begin
            w_data2 = r_regs[addr2];
            w_pend2 = r_pend[addr2];
        end
`else
        // Without forwarding, a write is only visible after its edge.
        if (write) begin
            w_data1 = r_regs[addr1];
        end else begin
            w_data2 = r_regs[addr2];
        end
`endif
    end

    assign data1    = w_data1;
    assign data2    = w_data2;
    assign pend1    = w_pend1;
    assign pend2    = w_pend2;
    assign clr_busy = r_clr_busy;

endmodule
